// File: rtl/gpr_block_transfer.sv
// gpr_block_transfer
// Moves the eight-entry GPR file to or from a word stream. It is used for
// PUSHA/POPA-style microcode and for context save/restore.
// A save reads AX,CX,DX,BX,SP,BP,SI,DI through read port 0 and sends them out
// through a two-entry skid FIFO. A restore writes the incoming words to
// DI,SI,BP,SP,BX,DX,CX,AX, in that order.
module gpr_block_transfer #(
  parameter bit SKIP_SP_ON_RESTORE = 1'b1,
  parameter int WIDTH              = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_save,
  input  logic             start_restore,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [2:0]       rf_rd_sel,
  input  logic [WIDTH-1:0] rf_rd_val,
  output logic [2:0]       rf_wr_sel,
  output logic [WIDTH-1:0] rf_wr_val,
  output logic             rf_wr_en,
  output logic             rf_is_8_bit
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } state_e;

  localparam logic [3:0] NUM_REGS  = 4'd8;
  localparam logic [3:0] LAST_WORD = 4'd7;
  localparam logic [3:0] SP_SLOT   = 4'd3;

  state_e           state_q, state_d;
  logic [3:0]       ri_q, ri_d;             // next register to read (save)
  logic [3:0]       po_q, po_d;             // words handed to the consumer (save)
  logic             inflight_q, inflight_d; // a read was issued last cycle
  logic [WIDTH-1:0] fifo_q [2];
  logic [WIDTH-1:0] fifo_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [3:0]       wi_q, wi_d;             // restore words accepted
  logic             done_q, done_d;
  logic             wr_en_q, wr_en_d;
  logic [2:0]       wr_sel_q, wr_sel_d;
  logic [WIDTH-1:0] wr_val_q, wr_val_d;

  logic             pop;
  logic             push;
  logic             issue;
  logic             accept;
  logic [2:0]       occupancy;

  // Handshake qualifiers and the read-issue throttle.
  // A read is issued only when the FIFO is sure to have a free slot when its data returns.
  always_comb begin
    pop       = (state_q == ST_SAVE) && (count_q != 2'd0) && out_ready;
    push      = inflight_q;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    issue     = (state_q == ST_SAVE) && (ri_q < NUM_REGS) &&
                (occupancy < (3'd2 + {2'b00, pop}));
    accept    = (state_q == ST_RESTORE) && (wi_q < NUM_REGS) && in_valid;
  end

  // Next-state logic, datapath updates and registered outputs.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave
    // one unassigned and infer a latch.
    state_d    = state_q;
    ri_d       = ri_q;
    po_d       = po_q;
    inflight_d = issue;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    wi_d       = wi_q;
    done_d     = 1'b0;
    wr_en_d    = 1'b0;
    wr_sel_d   = wr_sel_q;
    wr_val_d   = wr_val_q;

    if (push) begin
      fifo_d[wr_ptr_q] = rf_rd_val;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (issue) begin
      ri_d = ri_q + 4'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        // A save takes priority when both starts arrive together.
        if (start_save) begin
          state_d = ST_SAVE;
          ri_d    = 4'd0;
          po_d    = 4'd0;
        end else if (start_restore) begin
          state_d = ST_RESTORE;
          wi_d    = 4'd0;
        end
      end
      ST_SAVE: begin
        if (pop) begin
          po_d = po_q + 4'd1;
          if (po_q == LAST_WORD) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RESTORE: begin
        if (accept) begin
          wi_d     = wi_q + 4'd1;
          wr_sel_d = 3'd7 - wi_q[2:0];
          wr_val_d = in_data;
          wr_en_d  = !(SKIP_SP_ON_RESTORE && (wi_q == SP_SLOT));
          // done is registered, so it appears in the same cycle as the final write.
          if (wi_q == LAST_WORD) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  // A reset discards any in-flight read, the FIFO contents and a pending write.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples values from before the edge.
    if (reset) begin
      state_q    <= ST_IDLE;
      ri_q       <= 4'd0;
      po_q       <= 4'd0;
      inflight_q <= 1'b0;
      // NOTE: the two FIFO words are cleared on reset, so out_data comes up 0;
      // with only two entries, resetting them costs little.
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      wi_q       <= 4'd0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= 3'd0;
      wr_val_q   <= '0;
    end else begin
      state_q    <= state_d;
      ri_q       <= ri_d;
      po_q       <= po_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wi_q       <= wi_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      wr_sel_q   <= wr_sel_d;
      wr_val_q   <= wr_val_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_data    = fifo_q[rd_ptr_q];
  assign in_ready    = (state_q == ST_RESTORE) && (wi_q < NUM_REGS);
  assign rf_rd_sel   = ri_q[2:0];
  assign rf_wr_sel   = wr_sel_q;
  assign rf_wr_val   = wr_val_q;
  assign rf_wr_en    = wr_en_q;
  assign rf_is_8_bit = 1'b0;

endmodule

// File: tb/tb_gpr_block_transfer.sv
// Testbench for gpr_block_transfer.
// Two instances share all stimulus. dut0 uses the default SP skip; dut1 writes
// all eight restore words. Each instance has its own register-file model.
module tb_gpr_block_transfer;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start_save, start_restore, out_ready, in_valid;
  logic [W-1:0] in_data;

  logic         busy0, done0, out_valid0, in_ready0, rf_wr_en0, rf_is_8_bit0;
  logic [W-1:0] out_data0, rf_wr_val0, rf_rd_val0;
  logic [2:0]   rf_rd_sel0, rf_wr_sel0;
  logic         busy1, done1, out_valid1, in_ready1, rf_wr_en1, rf_is_8_bit1;
  logic [W-1:0] out_data1, rf_wr_val1, rf_rd_val1;
  logic [2:0]   rf_rd_sel1, rf_wr_sel1;

  gpr_block_transfer #(.SKIP_SP_ON_RESTORE(1'b1), .WIDTH(W)) dut0 (
    .clk(clk), .reset(reset), .start_save(start_save), .start_restore(start_restore),
    .busy(busy0), .done(done0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .rf_rd_sel(rf_rd_sel0), .rf_rd_val(rf_rd_val0), .rf_wr_sel(rf_wr_sel0),
    .rf_wr_val(rf_wr_val0), .rf_wr_en(rf_wr_en0), .rf_is_8_bit(rf_is_8_bit0)
  );

  gpr_block_transfer #(.SKIP_SP_ON_RESTORE(1'b0), .WIDTH(W)) dut1 (
    .clk(clk), .reset(reset), .start_save(start_save), .start_restore(start_restore),
    .busy(busy1), .done(done1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .rf_rd_sel(rf_rd_sel1), .rf_rd_val(rf_rd_val1), .rf_wr_sel(rf_wr_sel1),
    .rf_wr_val(rf_wr_val1), .rf_wr_en(rf_wr_en1), .rf_is_8_bit(rf_is_8_bit1)
  );

  // Register-file models: registered read, write on rf_wr_en, plus a preload port.
  logic [W-1:0] rf0 [8];
  logic [W-1:0] rf1 [8];
  logic         ld_en;
  logic [2:0]   ld_sel;
  logic [W-1:0] ld_val;

  always @(posedge clk) begin
    rf_rd_val0 <= rf0[rf_rd_sel0];
    rf_rd_val1 <= rf1[rf_rd_sel1];
    if (ld_en) begin
      rf0[ld_sel] <= ld_val;
      rf1[ld_sel] <= ld_val;
    end else begin
      if (rf_wr_en0) rf0[rf_wr_sel0] <= rf_wr_val0;
      if (rf_wr_en1) rf1[rf_wr_sel1] <= rf_wr_val1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard state. Only the monitor below writes it.
  typedef struct packed {
    logic [2:0]   sel;
    logic [W-1:0] val;
  } wr_t;

  logic [W-1:0] img [8];        // register values the bench expects before a save
  logic [W-1:0] sq [$];         // expected save words
  wr_t          wq0 [$];
  wr_t          wq1 [$];
  int           hs_total   = 0;
  int           hs_cyc [64];
  int           done_total = 0;
  int           done_cyc   = 0;
  int           acc_total  = 0;
  int           acc_cyc    = 0;
  int           acc_k      = 0;
  bit           wen_exp0   = 1'b0;
  bit           wen_exp1   = 1'b0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;
  bit           is8_seen   = 1'b0;
  bit           mon_on     = 1'b0;
  bit           acc0, acc1;

  // Monitor: samples on the falling edge, while inputs and outputs are stable.
  always @(negedge clk) begin
    if (rf_is_8_bit0 || rf_is_8_bit1) is8_seen = 1'b1;

    if (mon_on) begin
      check("wr_en0_timing", {31'd0, rf_wr_en0}, {31'd0, wen_exp0});
      check("wr_en1_timing", {31'd0, rf_wr_en1}, {31'd0, wen_exp1});
      if (stall_prev) begin
        check("stall_hold_valid", {31'd0, out_valid0}, 32'd1);
        check("stall_hold_data", {16'd0, out_data0}, {16'd0, stall_data});
      end
    end
    stall_prev = out_valid0 && !out_ready && !reset;
    stall_data = out_data0;

    if (rf_wr_en0 && wq0.size() > 0) begin
      wr_t e;
      e = wq0.pop_front();
      check("wr0_sel", {29'd0, rf_wr_sel0}, {29'd0, e.sel});
      check("wr0_val", {16'd0, rf_wr_val0}, {16'd0, e.val});
    end
    if (rf_wr_en1 && wq1.size() > 0) begin
      wr_t e;
      e = wq1.pop_front();
      check("wr1_sel", {29'd0, rf_wr_sel1}, {29'd0, e.sel});
      check("wr1_val", {16'd0, rf_wr_val1}, {16'd0, e.val});
    end

    acc0 = in_valid && in_ready0 && !reset;
    acc1 = in_valid && in_ready1 && !reset;
    wen_exp0 = acc0 && (acc_k != 3);
    wen_exp1 = acc1;
    if (acc1) wq1.push_back('{sel: 3'(7 - acc_k), val: in_data});
    if (acc0) begin
      if (acc_k != 3) wq0.push_back('{sel: 3'(7 - acc_k), val: in_data});
      acc_k++;
      acc_total++;
      acc_cyc = cyc;
    end

    if (out_valid0 && out_ready && !reset) begin
      if (sq.size() > 0) check("save_word", {16'd0, out_data0}, {16'd0, sq.pop_front()});
      else check("save_word_unexpected", {16'd0, out_data0}, 32'hFFFF_FFFF);
      hs_cyc[hs_total % 64] = cyc;
      hs_total++;
    end

    if (done0 && !reset) begin
      done_total++;
      done_cyc = cyc;
    end

    if (reset) begin
      sq.delete();
      wq0.delete();
      wq1.delete();
    end else if (!busy0 && start_save) begin
      for (int i = 0; i < 8; i++) sq.push_back(img[i]);
    end else if (!busy0 && start_restore) begin
      acc_k = 0;
    end
  end

  task automatic wait_done(input int base, input int budget);
    for (int i = 0; i < budget && done_total == base; i++) tick();
    if (done_total == base) check("done_timeout", done_total, base + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] data;
    int           gap;
    int           dst;
    bit           written;
  } rvec_t;

  bit    rdy_pat [4];
  rvec_t rt [8];

  initial begin
    int n, base_hs, base_done, base_acc;
    logic [W-1:0] exp_v;

    // Restore vectors: word k goes to register 7-k; with the default skip, the SP slot is not written.
    rt[0] = '{16'hA0A0, 0, 7, 1'b1};
    rt[1] = '{16'hA1A1, 2, 6, 1'b1};
    rt[2] = '{16'hA2A2, 0, 5, 1'b1};
    rt[3] = '{16'hA3A3, 1, 4, 1'b0};
    rt[4] = '{16'hA4A4, 0, 3, 1'b1};
    rt[5] = '{16'hA5A5, 3, 2, 1'b1};
    rt[6] = '{16'hA6A6, 0, 1, 1'b1};
    rt[7] = '{16'hA7A7, 1, 0, 1'b1};
    rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;

    reset = 1'b1; start_save = 1'b0; start_restore = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_data = '0; ld_en = 1'b0; ld_sel = 3'd0; ld_val = '0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    check("rst_out_data", {16'd0, out_data0}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready0}, 32'd0);
    check("rst_wr_en", {31'd0, rf_wr_en0}, 32'd0);
    check("rst_wr_sel", {29'd0, rf_wr_sel0}, 32'd0);
    check("rst_wr_val", {16'd0, rf_wr_val0}, 32'd0);
    check("rst_rd_sel", {29'd0, rf_rd_sel0}, 32'd0);
    reset = 1'b0;
    tick();
    mon_on = 1'b1;

    // Preload AX..DI = 1111..8888
    for (int i = 0; i < 8; i++) begin
      ld_en = 1'b1; ld_sel = 3'(i); ld_val = 16'(16'h1111 * (i + 1));
      img[i] = 16'(16'h1111 * (i + 1));
      tick();
    end
    ld_en = 1'b0;
    tick();

    // Save with out_ready held high: words at T+3..T+10, done at T+11
    out_ready = 1'b1;
    base_hs = hs_total; base_done = done_total;
    n = cyc;
    start_save = 1'b1;
    tick();
    start_save = 1'b0;
    wait_done(base_done, 40);
    check("save1_word_count", hs_total - base_hs, 8);
    check("save1_first_cycle", hs_cyc[base_hs % 64], n + 3);
    check("save1_last_cycle", hs_cyc[(base_hs + 7) % 64], n + 10);
    check("save1_done_cycle", done_cyc, n + 11);
    check("save1_busy_after", {31'd0, busy0}, 32'd0);
    check("save1_queue_empty", sq.size(), 0);

    // Save with out_ready stalling in the repeating pattern 1,0,0,1
    tick();
    base_hs = hs_total; base_done = done_total;
    out_ready = rdy_pat[0];
    start_save = 1'b1;
    tick();
    start_save = 1'b0;
    for (int c = 1; c < 120 && done_total == base_done; c++) begin
      out_ready = rdy_pat[c % 4];
      tick();
    end
    check("stall_done_seen", done_total, base_done + 1);
    check("stall_word_count", hs_total - base_hs, 8);
    check("stall_queue_empty", sq.size(), 0);

    // Both starts together -> save runs; starts during the save are ignored
    out_ready = 1'b1;
    tick();
    base_hs = hs_total; base_done = done_total; base_acc = acc_total;
    start_save = 1'b1; start_restore = 1'b1;
    tick();
    start_save = 1'b0; start_restore = 1'b0;
    repeat (3) tick();
    check("both_busy_mid", {31'd0, busy0}, 32'd1);
    start_save = 1'b1; start_restore = 1'b1;
    tick();
    start_save = 1'b0; start_restore = 1'b0;
    wait_done(base_done, 40);
    repeat (5) tick();
    check("both_word_count", hs_total - base_hs, 8);
    check("both_done_once", done_total - base_done, 1);
    check("both_no_accepts", acc_total - base_acc, 0);
    check("both_idle_after", {31'd0, busy0}, 32'd0);

    // Reset asserted while the 4th save word waits with out_ready low
    base_hs = hs_total;
    start_save = 1'b1;
    tick();
    start_save = 1'b0;
    for (int i = 0; i < 30 && hs_total != base_hs + 3; i++) tick();
    check("rst_mid_three_words", hs_total - base_hs, 3);
    check("rst_mid_4th_valid", {31'd0, out_valid0}, 32'd1);
    check("rst_mid_4th_data", {16'd0, out_data0}, {16'd0, img[3]});
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy0}, 32'd0);
    check("rst_mid_out_valid", {31'd0, out_valid0}, 32'd0);
    tick();
    out_ready = 1'b1;
    base_hs = hs_total; base_done = done_total;
    start_save = 1'b1;
    tick();
    start_save = 1'b0;
    wait_done(base_done, 40);
    check("resave_word_count", hs_total - base_hs, 8);
    check("resave_queue_empty", sq.size(), 0);

    // Restore from the vector table, with gaps in in_valid
    tick();
    base_done = done_total;
    start_restore = 1'b1;
    tick();
    start_restore = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat (rt[k].gap) tick();
      in_valid = 1'b1;
      in_data  = rt[k].data;
      base_acc = acc_total;
      for (int i = 0; i < 20 && acc_total == base_acc; i++) tick();
      if (acc_total == base_acc) check("accept_timeout", acc_total, base_acc + 1);
      in_valid = 1'b0;
    end
    wait_done(base_done, 10);
    check("restore_done_cycle", done_cyc, acc_cyc + 1);
    tick();
    check("restore_in_ready_after", {31'd0, in_ready0}, 32'd0);
    check("restore_busy_after", {31'd0, busy0}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      exp_v = rt[k].written ? rt[k].data : img[rt[k].dst];
      check($sformatf("restore0_reg%0d", rt[k].dst), {16'd0, rf0[rt[k].dst]}, {16'd0, exp_v});
      check($sformatf("restore1_reg%0d", rt[k].dst), {16'd0, rf1[rt[k].dst]}, {16'd0, rt[k].data});
    end
    check("wr0_queue_empty", wq0.size(), 0);
    check("wr1_queue_empty", wq1.size(), 0);
    check("is_8_bit_never", {31'd0, is8_seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
